// File: rtl/uart_tx_sched.sv
// Purpose : configures a UART (baud divider, then enable) and streams queued bytes to its TX register.
// Latency : config writes 1 and 2 cycles after start; a queued byte is written 1 cycle after READY sees it.
// Backpr. : CPU writes pre-empt the scheduler (CFG/SEND hold); push while full is dropped; sends pace on tx_busy.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, cfg_div             start the config sequence; divider for UART reg 3
//   push, push_data            FIFO write strobe and byte; full/empty are FIFO flags
//   cpu_we, cpu_reg, cpu_wd    CPU pass-through write; always wins the UART write port
//   tx_busy                    UART transmitter busy
//   uart_we, uart_reg_num,     UART register write port (combinational)
//   uart_wd
//   ready                      configured and idle; err sticky send timeout
module uart_tx_sched #(
  parameter int DEPTH    = 8,
  parameter int BUSY_TMO = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cfg_div,
  input  logic        push,
  input  logic [7:0]  push_data,
  output logic        full,
  output logic        empty,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_reg,
  input  logic [31:0] cpu_wd,
  input  logic        tx_busy,
  output logic        uart_we,
  output logic [2:0]  uart_reg_num,
  output logic [31:0] uart_wd,
  output logic        ready,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO + 1) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_TXD  = 3'd2;
  localparam logic [2:0] REG_DIV  = 3'd3;

  typedef enum logic [2:0] {
    UNCFG, CFG_DIV, CFG_EN, READY, SEND, WAIT_BUSY, WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  // ---------------- byte FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_en, rd_en, pop;
  logic [7:0]    head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy lives in count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- scheduler FSM ----------------
  logic [TW-1:0] tmo_cnt;
  logic          tmo_fire;
  logic          fsm_we;
  logic [2:0]    fsm_reg;
  logic [31:0]   fsm_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNCFG;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo_fire  = 1'b0;
    fsm_we    = 1'b0;
    fsm_reg   = 3'd0;
    fsm_wd    = 32'd0;
    case (state)
      UNCFG: begin
        if (start) state_nxt = CFG_DIV;
      end
      // Write states only advance on a cycle the CPU leaves the port free.
      CFG_DIV: begin
        fsm_we  = 1'b1;
        fsm_reg = REG_DIV;
        fsm_wd  = cfg_div;
        if (!cpu_we) state_nxt = CFG_EN;
      end
      CFG_EN: begin
        fsm_we  = 1'b1;
        fsm_reg = REG_CTRL;
        fsm_wd  = 32'h1;
        if (!cpu_we) state_nxt = READY;
      end
      READY: begin
        if (start)       state_nxt = CFG_DIV;
        else if (!empty) state_nxt = SEND;
      end
      SEND: begin
        fsm_we  = 1'b1;
        fsm_reg = REG_TXD;
        fsm_wd  = {24'h0, head};
        if (!cpu_we) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = READY;
          tmo_fire  = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = READY;
      end
      default: state_nxt = UNCFG;
    endcase
  end

  // Counts consecutive idle-busy cycles spent in WAIT_BUSY; zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_BUSY && !tx_busy) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state_nxt == CFG_DIV && state != CFG_DIV) begin
      err <= 1'b0;
    end else if (tmo_fire) begin
      err <= 1'b1;
    end
  end

  assign ready = (state == READY);

  // CPU has fixed priority on the UART write port.
  assign uart_we      = cpu_we || fsm_we;
  assign uart_reg_num = cpu_we ? cpu_reg : fsm_reg;
  assign uart_wd      = cpu_we ? cpu_wd  : fsm_wd;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, push, cpu_we, tx_busy;
  logic [31:0] cfg_div, cpu_wd;
  logic [7:0]  push_data;
  logic [2:0]  cpu_reg;
  logic        full, empty, uart_we, ready, err;
  logic [2:0]  uart_reg_num;
  logic [31:0] uart_wd;

  uart_tx_sched #(.DEPTH(DEPTH), .BUSY_TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_div(cfg_div),
    .push(push), .push_data(push_data), .full(full), .empty(empty),
    .cpu_we(cpu_we), .cpu_reg(cpu_reg), .cpu_wd(cpu_wd), .tx_busy(tx_busy),
    .uart_we(uart_we), .uart_reg_num(uart_reg_num), .uart_wd(uart_wd),
    .ready(ready), .err(err)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t        sb_q[$];        // expected UART writes, in order
  logic [7:0] model_fifo[$];  // bytes held while unconfigured
  bit         configured;
  int         n_cmp = 0;
  int         n_err = 0;
  int         busy_len = 10;
  bit         busy_en = 1'b1;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         last_send = -1000;

  function automatic wr_t mk(input logic [2:0] r, input logic [31:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // UART side: scoreboard monitor plus a tx_busy model, sampled mid-cycle.
  initial begin
    wr_t e;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy_cnt > 0) busy_cnt--;
      if (uart_we) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL uart_write: got unexpected reg%0d wd=%h want no write", uart_reg_num, uart_wd);
        end else begin
          e = sb_q.pop_front();
          if (e.r !== uart_reg_num || e.d !== uart_wd) begin
            n_err++;
            $display("FAIL uart_write: got reg%0d wd=%h want reg%0d wd=%h",
                     uart_reg_num, uart_wd, e.r, e.d);
          end
        end
        if (!cpu_we && uart_reg_num == 3'd2) begin
          chk("send_while_busy", 32'(tx_busy), 32'd0);
          chk("send_spacing_ok", 32'(cyc - last_send >= 4), 32'd1);
          last_send = cyc;
          if (busy_en) busy_cnt = busy_len;
        end
      end
      if (!rst_n) busy_cnt = 0;
      tx_busy = (busy_cnt != 0);
    end
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    chk("sb_empty_before_reset", 32'(sb_q.size()), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    configured = 1'b0;
    model_fifo.delete();
    sb_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    push = 1'b1;
    push_data = b;
    if (configured) sb_q.push_back(mk(3'd2, {24'h0, b}));
    else if (model_fifo.size() < DEPTH) model_fifo.push_back(b);
    step();
    push = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] r, input logic [31:0] d);
    cpu_we = 1'b1;
    cpu_reg = r;
    cpu_wd = d;
    sb_q.push_back(mk(r, d));
    step();
    cpu_we = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] div);
    start = 1'b1;
    cfg_div = div;
    sb_q.push_back(mk(3'd3, div));
    sb_q.push_back(mk(3'd0, 32'h1));
    while (model_fifo.size() > 0) sb_q.push_back(mk(3'd2, {24'h0, model_fifo.pop_front()}));
    configured = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max, input string nm);
    int i;
    for (i = 0; i < max; i++) begin
      if (sb_q.size() == 0 && ready && empty) break;
      step();
    end
    chk(nm, 32'(i < max), 32'd1);
  endtask

  initial begin
    logic [7:0]  b1, b2;
    logic [31:0] d;
    int          n;
    rst_n = 1'b0; start = 1'b0; push = 1'b0; cpu_we = 1'b0;
    cfg_div = '0; cpu_wd = '0; push_data = '0; cpu_reg = '0;
    configured = 1'b0;
    step(); step();

    // reset state
    chk("rst_ready", 32'(ready), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_uart_we", 32'(uart_we), 0);
    chk("rst_uart_reg", 32'(uart_reg_num), 0);
    chk("rst_uart_wd", uart_wd, 0);
    rst_n = 1'b1;
    step();

    // config sequence with cycle-exact writes
    do_start(32'h7F);
    chk("cfg1_we", 32'(uart_we), 1);
    chk("cfg1_reg", 32'(uart_reg_num), 3);
    chk("cfg1_wd", uart_wd, 32'h7F);
    chk("cfg1_ready", 32'(ready), 0);
    step();
    chk("cfg2_reg", 32'(uart_reg_num), 0);
    chk("cfg2_wd", uart_wd, 1);
    chk("cfg2_ready", 32'(ready), 0);
    step();
    chk("cfg3_ready", 32'(ready), 1);
    chk("cfg3_we", 32'(uart_we), 0);

    // two sends paced by tx_busy
    busy_len = 10;
    push_byte(8'h55);
    push_byte(8'hA3);
    wait_drain(200, "send_drain");
    chk("send_empty", 32'(empty), 1);

    // CPU pre-empts CFG_DIV for three cycles
    repeat (3) sb_q.push_back(mk(3'd2, 32'h11));
    do_start(32'h0000_1234);
    cpu_we = 1'b1; cpu_reg = 3'd2; cpu_wd = 32'h11;
    step(); step(); step();
    cpu_we = 1'b0;
    step();
    chk("arb_ready_early", 32'(ready), 0);
    step();
    chk("arb_ready", 32'(ready), 1);
    chk("arb_sb_done", 32'(sb_q.size()), 0);

    // tx_busy never rises: timeout after 15 cycles in WAIT_BUSY
    busy_en = 1'b0;
    push_byte(8'h3C);
    step();
    chk("tmo_send_ready", 32'(ready), 0);
    repeat (15) step();
    chk("tmo_not_yet", 32'(ready), 0);
    chk("tmo_err_not_yet", 32'(err), 0);
    step();
    chk("tmo_ready", 32'(ready), 1);
    chk("tmo_err", 32'(err), 1);
    step(); step();
    chk("tmo_err_sticky", 32'(err), 1);
    busy_en = 1'b1;
    do_start(32'h55);
    chk("tmo_err_cleared", 32'(err), 0);
    step(); step();
    chk("tmo_recfg_ready", 32'(ready), 1);

    // async reset in the middle of WAIT_DONE
    busy_len = 10;
    b1 = 8'($urandom); b2 = 8'($urandom);
    push_byte(b1);
    push = 1'b1; push_data = b2;   // queued but discarded by the reset below
    step();
    push = 1'b0;
    step(); step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_uart_we", 32'(uart_we), 0);
    configured = 1'b0;
    model_fifo.delete();
    step();
    d = $urandom;
    cpu_write(3'd5, d);            // pass-through still works under reset
    rst_n = 1'b1;
    repeat (30) step();
    chk("arst_no_writes", 32'(sb_q.size()), 0);

    // FIFO boundary: 9 pushes while unconfigured, 9th dropped
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push_byte(8'(i));
      if (i == 7) chk("fifo_not_full_7", 32'(full), 0);
      if (i >= 8) chk("fifo_full", 32'(full), 1);
    end
    chk("fifo_not_empty", 32'(empty), 0);
    busy_len = 3;
    do_start(32'h9);
    wait_drain(300, "fifo_drain");
    chk("fifo_empty_end", 32'(empty), 1);
    chk("fifo_full_end", 32'(full), 0);

    // push and pop on the same edge (first SEND cycle)
    do_reset();
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    do_start(32'hABCD);
    step(); step(); step();        // now in SEND
    push_byte(8'hA4);
    chk("pp_not_empty", 32'(empty), 0);
    chk("pp_not_full", 32'(full), 0);
    wait_drain(300, "pp_drain");

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      do_reset();
      cpu_write(3'($urandom), $urandom);
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) push_byte(8'($urandom));
      chk("rnd_full", 32'(full), 32'(n >= DEPTH));
      chk("rnd_not_empty", 32'(empty), 0);
      busy_len = $urandom_range(2, 8);
      do_start($urandom);
      wait_drain(400, "rnd_drain");
      chk("rnd_empty", 32'(empty), 1);
    end

    step();
    chk("sb_final", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter BUSY_TMO, default 15, max cycles in WAIT_BUSY before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse; requests the UART config sequence.
REQ-006 cfg_div  in  32  baud divider written to UART reg 3.
REQ-007 push  in  1  FIFO write strobe.
REQ-008 push_data  in  8  byte to transmit.
REQ-009 full  out  1  FIFO holds DEPTH entries.
REQ-010 empty  out  1  FIFO holds 0 entries.
REQ-011 cpu_we  in  1  CPU pass-through write request to UART.
REQ-012 cpu_reg  in  3  CPU target register number.
REQ-013 cpu_wd  in  32  CPU write data.
REQ-014 tx_busy  in  1  UART transmitter busy.
REQ-015 uart_we  out  1  write strobe to UART (drives UART we).
REQ-016 uart_reg_num  out  3  register number to UART.
REQ-017 uart_wd  out  32  write data to UART.
REQ-018 ready  out  1  config done, scheduler idle and able to send.
REQ-019 err  out  1  sticky: a send timed out waiting for tx_busy.

Function
REQ-020 UART register map: reg 0 = control (bit0 enable), reg 2 = TX data (bits 7:0), reg 3 = baud divider.
REQ-021 States: UNCFG, CFG_DIV, CFG_EN, READY, SEND, WAIT_BUSY, WAIT_DONE.
REQ-022 UNCFG or READY with start=1 -> CFG_DIV next cycle; start in any other state is ignored.
REQ-023 CFG_DIV: drive write reg 3, wd=cfg_div (sampled that cycle) -> CFG_EN.
REQ-024 CFG_EN: drive write reg 0, wd=32'h1 -> READY.
REQ-025 READY with !empty and start=0 -> SEND; start has priority over sending.
REQ-026 SEND: drive write reg 2, wd={24'b0, head byte}; pop FIFO same edge -> WAIT_BUSY.
REQ-027 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; BUSY_TMO consecutive cycles with tx_busy=0 -> READY and set err.
REQ-028 WAIT_DONE: tx_busy=0 -> READY; no timeout.
REQ-029 Arbitration is fixed CPU priority. When cpu_we=1, uart_* outputs mirror cpu_wd/cpu_reg with uart_we=1. CFG_DIV, CFG_EN and SEND hold state, with no pop and no advance, until a cycle with cpu_we=0.
REQ-030 uart_* outputs are combinational from state, FIFO head and CPU inputs. uart_we=0, uart_reg_num=0, uart_wd=0 when no writer is active.
REQ-031 ready=1 only in READY.
REQ-032 Minimum byte-to-byte spacing is SEND + 1 WAIT_BUSY + 1 WAIT_DONE + 1 READY = 4 cycles.
REQ-033 FIFO accepts push iff full=0 at that edge; push while full is dropped with no state change.
REQ-034 Simultaneous push and pop when not full or empty: count unchanged, both take effect.
REQ-035 Read and write pointers wrap modulo DEPTH; count is tracked in a separate log2(DEPTH)+1-bit counter.
REQ-036 Byte order out equals push order.
REQ-037 err clears only on reset or on entry to CFG_DIV.

Reset
REQ-038 rst_n=0 asynchronously forces: state UNCFG, FIFO empty (pointers and count 0), err=0, ready=0.
REQ-039 Reset forces FIFO flags full=0, empty=1.
REQ-040 Reset forces UART outputs uart_we=0, uart_reg_num=0, uart_wd=0, except that the CPU pass-through mirror still applies while cpu_we=1.
REQ-041 Reset mid-transmission discards queued bytes; no further UART writes are issued until a new start.

Verification
REQ-042 Config: reset, then start with cfg_div=32'h7F -> cycle+1 write reg3 wd=0x7F; cycle+2 write reg0 wd=1; ready=1 at cycle+3.
REQ-043 Send: after config, push 0x55 and 0xA3; model tx_busy high 10 cycles after each reg2 write -> writes reg2 0x55, then reg2 0xA3 only after tx_busy falls; empty=1 at end.
REQ-044 Arbitration: cpu_we=1 with reg 2, wd=0x11, held 3 cycles during CFG_DIV -> UART sees three CPU writes of 0x11, then reg3 write, then reg0 write; no cycles lost.
REQ-045 FIFO boundary: push 9 bytes 0x01..0x09 while unconfigured -> full=1 after 8th, 0x09 dropped. Push+pop in the same cycle keeps count; output order is 0x01..0x08.
REQ-046 Timeout: tx_busy held 0 after a SEND -> READY after 15 cycles, err=1. A new start clears err.
REQ-047 Async reset: assert rst_n=0 mid-WAIT_DONE between clock edges -> immediately ready=0, empty=1, uart_we=0.
